// File: rtl/l1_cache_pkg.sv
// Shared types and derived-geometry helpers for the L1 write-back data cache.
package l1_cache_pkg;

  typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, REFILL} state_e;

  // Tags are stored zero-extended to a fixed width so the metadata struct stays parameter-free.
  localparam int unsigned TAG_MAX = 32;

  typedef struct packed {
    logic               valid;
    logic               dirty;
    logic [TAG_MAX-1:0] tag;
  } line_meta_t;

  function automatic int unsigned f_num_sets(input int unsigned cache_size, input int unsigned block_size,
                                             input int unsigned num_ways);
    return cache_size / (block_size * num_ways);
  endfunction

  function automatic int unsigned f_off(input int unsigned block_size);
    return $clog2(block_size);
  endfunction

  function automatic int unsigned f_idx(input int unsigned cache_size, input int unsigned block_size,
                                        input int unsigned num_ways);
    return $clog2(f_num_sets(cache_size, block_size, num_ways));
  endfunction

  function automatic int unsigned f_tag(input int unsigned addr_width, input int unsigned cache_size,
                                        input int unsigned block_size, input int unsigned num_ways);
    return addr_width - f_idx(cache_size, block_size, num_ways) - f_off(block_size);
  endfunction

  function automatic int unsigned f_safe(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic logic [15:0] f_sat_inc(input logic [15:0] v, input logic inc);
    return (inc && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/l1_lru_ages.sv
// Per-set true-LRU age table: age 0 is most recent, age NUM_WAYS-1 is the replacement candidate.
module l1_lru_ages
  import l1_cache_pkg::*;
#(
  parameter int unsigned NUM_WAYS = 4,
  parameter int unsigned NUM_SETS = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [f_safe($clog2(NUM_SETS))-1:0]     i_set,
  input  logic                                    i_touch,
  input  logic [f_safe($clog2(NUM_WAYS))-1:0]     i_way,
  output logic [f_safe($clog2(NUM_WAYS))-1:0]     o_victim
);

  localparam int unsigned WAY_W = f_safe($clog2(NUM_WAYS));

  logic [WAY_W-1:0] r_age [NUM_SETS][NUM_WAYS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          r_age[s][w] <= WAY_W'(w);
    end else if (i_touch) begin
      // Only ways younger than the touched one shift, so ages remain a permutation.
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (WAY_W'(w) == i_way)
          r_age[i_set][w] <= '0;
        else if (r_age[i_set][w] < r_age[i_set][i_way])
          r_age[i_set][w] <= r_age[i_set][w] + 1'b1;
      end
    end
  end

  always_comb begin
    o_victim = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (r_age[i_set][w] == WAY_W'(NUM_WAYS - 1))
        o_victim = WAY_W'(w);
  end

endmodule

// File: rtl/l1_wb_cache.sv
// N-way set-associative write-back / write-allocate L1 data cache with true-LRU replacement.
// Optional event counters are built when L1_STATS_EN is defined.
//
//   state     | meaning
//   IDLE      | ready for a CPU request
//   LOOKUP    | tag compare in the indexed set, hit completes here
//   WRITEBACK | dirty victim block being written to L2
//   REFILL    | requested block being fetched from L2
module l1_wb_cache
  import l1_cache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CACHE_SIZE = 256,
  parameter int unsigned BLOCK_SIZE = 16,
  parameter int unsigned NUM_WAYS   = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [ADDR_WIDTH-1:0]                 cpu_addr,
  input  logic [DATA_WIDTH-1:0]                 cpu_data_in,
  input  logic                                  cpu_read,
  input  logic                                  cpu_write,
  output logic [DATA_WIDTH-1:0]                 cpu_data_out,
  output logic                                  cpu_ready,
  output logic                                  l1_hit,
  output logic [ADDR_WIDTH-1:0]                 l2_cache_addr,
  output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] l2_cache_data_out,
  input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] l2_cache_data_in,
  output logic                                  l2_cache_read,
  output logic                                  l2_cache_write,
  input  logic                                  l2_cache_ready,
  input  logic                                  l2_cache_hit
`ifdef L1_STATS_EN
  ,
  output logic [15:0]                           stat_hits,
  output logic [15:0]                           stat_misses,
  output logic [15:0]                           stat_writebacks,
  output logic [15:0]                           stat_l2_hits
`endif
);

  localparam int unsigned NUM_SETS = f_num_sets(CACHE_SIZE, BLOCK_SIZE, NUM_WAYS);
  localparam int unsigned OFF      = f_off(BLOCK_SIZE);
  localparam int unsigned IDX      = f_idx(CACHE_SIZE, BLOCK_SIZE, NUM_WAYS);
  localparam int unsigned TAG      = f_tag(ADDR_WIDTH, CACHE_SIZE, BLOCK_SIZE, NUM_WAYS);
  localparam int unsigned SET_W    = f_safe(IDX);
  localparam int unsigned OFF_W    = f_safe(OFF);
  localparam int unsigned WAY_W    = f_safe($clog2(NUM_WAYS));

  state_e                                r_state, w_next;
  logic [ADDR_WIDTH-1:0]                 r_addr;
  logic [DATA_WIDTH-1:0]                 r_wdata;
  logic                                  r_is_write;
  logic [WAY_W-1:0]                      r_victim;
  logic                                  r_ready;
  logic                                  r_hit;
  logic [DATA_WIDTH-1:0]                 r_data_out;
  line_meta_t                            r_meta [NUM_WAYS][NUM_SETS];
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] r_data [NUM_WAYS][NUM_SETS];

  logic [SET_W-1:0]                      w_idx;
  logic [OFF_W-1:0]                      w_off;
  logic [TAG_MAX-1:0]                    w_tag;
  logic                                  w_hit, w_free;
  logic [WAY_W-1:0]                      w_hit_way, w_free_way, w_lru_victim;
  logic                                  w_touch;
  logic [WAY_W-1:0]                      w_touch_way;
  logic                                  w_fill_done;
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] w_fill;

  assign w_idx       = (IDX == 0) ? '0 : SET_W'(r_addr >> OFF);
  assign w_off       = (OFF == 0) ? '0 : OFF_W'(r_addr);
  assign w_tag       = TAG_MAX'(r_addr >> (ADDR_WIDTH - TAG));
  assign w_fill_done = (r_state == REFILL) && l2_cache_ready;

  assign cpu_ready    = r_ready;
  assign l1_hit       = r_hit;
  assign cpu_data_out = r_data_out;

  // Descending scan so the lowest-numbered invalid way wins.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_way  = '0;
    w_free     = 1'b0;
    w_free_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (r_meta[w][w_idx].valid && r_meta[w][w_idx].tag == w_tag) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (!r_meta[w][w_idx].valid) begin
        w_free     = 1'b1;
        w_free_way = WAY_W'(w);
      end
    end
  end

  assign w_touch     = ((r_state == LOOKUP) && w_hit) || w_fill_done;
  assign w_touch_way = (r_state == LOOKUP) ? w_hit_way : r_victim;

  l1_lru_ages #(
    .NUM_WAYS (NUM_WAYS),
    .NUM_SETS (NUM_SETS)
  ) u_lru (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_set    (w_idx),
    .i_touch  (w_touch),
    .i_way    (w_touch_way),
    .o_victim (w_lru_victim)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (cpu_read || cpu_write) w_next = LOOKUP;
      LOOKUP: begin
        if (w_hit)
          w_next = IDLE;
        else if (!w_free && r_meta[w_lru_victim][w_idx].dirty)
          w_next = WRITEBACK;
        else
          w_next = REFILL;
      end
      WRITEBACK: if (l2_cache_ready) w_next = REFILL;
      REFILL:    if (l2_cache_ready) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_comb begin
    l2_cache_write    = (r_state == WRITEBACK);
    l2_cache_read     = (r_state == REFILL);
    l2_cache_data_out = r_data[r_victim][w_idx];
    case (r_state)
      WRITEBACK: l2_cache_addr = ADDR_WIDTH'(r_meta[r_victim][w_idx].tag << (OFF + IDX))
                               | (ADDR_WIDTH'(w_idx) << OFF);
      REFILL:    l2_cache_addr = r_addr & ~ADDR_WIDTH'(BLOCK_SIZE - 1);
      default:   l2_cache_addr = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_is_write <= 1'b0;
      r_victim   <= '0;
      r_ready    <= 1'b1;
      r_hit      <= 1'b0;
      r_data_out <= '0;
      for (int w = 0; w < NUM_WAYS; w++)
        for (int s = 0; s < NUM_SETS; s++)
          r_meta[w][s] <= '0;
    end else begin
      r_hit <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cpu_read || cpu_write) begin
            r_addr     <= cpu_addr;
            r_wdata    <= cpu_data_in;
            r_is_write <= cpu_write;
            r_ready    <= 1'b0;
          end
        end
        LOOKUP: begin
          if (w_hit) begin
            r_ready <= 1'b1;
            r_hit   <= 1'b1;
            if (r_is_write) r_meta[w_hit_way][w_idx].dirty <= 1'b1;
            else            r_data_out <= r_data[w_hit_way][w_idx][w_off];
          end else begin
            r_victim <= w_free ? w_free_way : w_lru_victim;
          end
        end
        REFILL: begin
          if (l2_cache_ready) begin
            r_meta[r_victim][w_idx] <= '{valid: 1'b1, dirty: r_is_write, tag: w_tag};
            r_ready <= 1'b1;
            if (!r_is_write) r_data_out <= l2_cache_data_in[w_off];
          end
        end
        default: ;
      endcase
    end
  end

  // A write miss merges its word into the incoming block before install.
  always_comb begin
    w_fill = l2_cache_data_in;
    if (r_is_write) w_fill[w_off] = r_wdata;
  end

  always_ff @(posedge clk) begin
    if ((r_state == LOOKUP) && w_hit && r_is_write)
      r_data[w_hit_way][w_idx][w_off] <= r_wdata;
    else if (w_fill_done)
      r_data[r_victim][w_idx] <= w_fill;
  end

`ifdef L1_STATS_EN
  logic [15:0] r_stat_hits, r_stat_misses, r_stat_wbs, r_stat_l2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_hits   <= '0;
      r_stat_misses <= '0;
      r_stat_wbs    <= '0;
      r_stat_l2     <= '0;
    end else begin
      r_stat_hits   <= f_sat_inc(r_stat_hits,   (r_state == LOOKUP) && w_hit);
      r_stat_misses <= f_sat_inc(r_stat_misses, (r_state == LOOKUP) && !w_hit);
      r_stat_wbs    <= f_sat_inc(r_stat_wbs,    (r_state == WRITEBACK) && l2_cache_ready);
      r_stat_l2     <= f_sat_inc(r_stat_l2,     w_fill_done && l2_cache_hit);
    end
  end

  assign stat_hits       = r_stat_hits;
  assign stat_misses     = r_stat_misses;
  assign stat_writebacks = r_stat_wbs;
  assign stat_l2_hits    = r_stat_l2;
`else
  logic w_unused;
  assign w_unused = l2_cache_hit;
`endif

endmodule

// File: tb/tb_l1_wb_cache.sv
// Directed bench for l1_wb_cache: block-level cache model (MRU-ordered queues) plus an L2 responder.
`timescale 1ns/1ps
module tb_l1_wb_cache;

  localparam int AW = 11;
  localparam int DW = 8;
  localparam int BS = 16;
  localparam int NW = 4;
  localparam int NS = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [AW-1:0]         cpu_addr;
  logic [DW-1:0]         cpu_data_in;
  logic                  cpu_read, cpu_write;
  logic [DW-1:0]         cpu_data_out;
  logic                  cpu_ready, l1_hit;
  logic [AW-1:0]         l2_cache_addr;
  logic [BS-1:0][DW-1:0] l2_cache_data_out;
  logic [BS-1:0][DW-1:0] l2_cache_data_in;
  logic                  l2_cache_read, l2_cache_write;
  logic                  l2_cache_ready, l2_cache_hit;
`ifdef L1_STATS_EN
  logic [15:0]           stat_hits, stat_misses, stat_writebacks, stat_l2_hits;
`endif

  always #5 clk = ~clk;

  l1_wb_cache dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cpu_addr          (cpu_addr),
    .cpu_data_in       (cpu_data_in),
    .cpu_read          (cpu_read),
    .cpu_write         (cpu_write),
    .cpu_data_out      (cpu_data_out),
    .cpu_ready         (cpu_ready),
    .l1_hit            (l1_hit),
    .l2_cache_addr     (l2_cache_addr),
    .l2_cache_data_out (l2_cache_data_out),
    .l2_cache_data_in  (l2_cache_data_in),
    .l2_cache_read     (l2_cache_read),
    .l2_cache_write    (l2_cache_write),
    .l2_cache_ready    (l2_cache_ready),
    .l2_cache_hit      (l2_cache_hit)
`ifdef L1_STATS_EN
    ,
    .stat_hits         (stat_hits),
    .stat_misses       (stat_misses),
    .stat_writebacks   (stat_writebacks),
    .stat_l2_hits      (stat_l2_hits)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each set is a list of resident blocks, most recently used first.
  typedef struct packed {
    logic [AW-1:0]    blk;
    logic             dirty;
    logic [BS*DW-1:0] data;
  } mline_t;

  mline_t        m_q [NS][$];
  logic [DW-1:0] m_mem  [2**AW];
  logic [DW-1:0] l2_mem [2**AW];

  bit            exp_pending = 0, exp_hit = 0, exp_wr = 0, exp_wb = 0;
  logic [AW-1:0] exp_wb_addr = '0, exp_rf_addr = '0;
  logic [127:0]  exp_wb_blk = '0;
  logic [DW-1:0] exp_rdata = '0, exp_hold = '0;
  bit            seen_wb = 0, seen_rf = 0, prev_ready = 1;

  int            l2_delay = 0, l2_cnt = 0, n_wb = 0;
  logic [AW-1:0] last_wb_addr = '0;

  task automatic model_access(input logic [AW-1:0] a, input bit wr, input logic [DW-1:0] wd);
    logic [AW-1:0] blk;
    int set, off, found;
    mline_t ln, v;
    blk = a & ~AW'(BS - 1);
    set = (int'(a) / BS) % NS;
    off = int'(a) % BS;
    found = -1;
    for (int i = 0; i < m_q[set].size(); i++)
      if (m_q[set][i].blk == blk) found = i;
    exp_wr = wr;
    exp_wb = 0;
    exp_rf_addr = blk;
    if (found >= 0) begin
      exp_hit = 1;
      ln = m_q[set][found];
      m_q[set].delete(found);
    end else begin
      exp_hit = 0;
      if (m_q[set].size() == NW) begin
        v = m_q[set].pop_back();
        if (v.dirty) begin
          exp_wb = 1;
          exp_wb_addr = v.blk;
          exp_wb_blk = v.data;
          for (int k = 0; k < BS; k++) m_mem[int'(v.blk) + k] = v.data[k*DW +: DW];
        end
      end
      ln.blk = blk;
      ln.dirty = 0;
      for (int k = 0; k < BS; k++) ln.data[k*DW +: DW] = m_mem[int'(blk) + k];
    end
    if (wr) begin
      ln.data[off*DW +: DW] = wd;
      ln.dirty = 1;
    end
    exp_rdata = ln.data[off*DW +: DW];
    m_q[set].push_front(ln);
  endtask

  // L2 responder: answers a strobe after l2_delay cycles with a one-cycle ready.
  always @(negedge clk) begin
    if (l2_cache_ready) begin
      l2_cache_ready = 1'b0;
      l2_cnt = 0;
    end else if (rst_n && (l2_cache_read || l2_cache_write)) begin
      if (l2_cnt >= l2_delay) begin
        l2_cache_ready = 1'b1;
        if (l2_cache_write) begin
          last_wb_addr = l2_cache_addr;
          n_wb++;
          for (int k = 0; k < BS; k++) l2_mem[int'(l2_cache_addr) + k] = l2_cache_data_out[k];
        end else begin
          for (int k = 0; k < BS; k++) l2_cache_data_in[k] = l2_mem[int'(l2_cache_addr) + k];
          l2_cache_hit = (l2_cache_addr < 11'h100);
        end
      end else begin
        l2_cnt++;
      end
    end else begin
      l2_cnt = 0;
    end
  end

  // Cycle-by-cycle comparison against the model's expectations.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ready = 1;
      exp_pending = 0;
      exp_hold = '0;
    end else begin
      chk("strobe_exclusive", l2_cache_read & l2_cache_write, 1'b0);
      if (l2_cache_write) begin
        chk("wb_expected", exp_pending && exp_wb, 1'b1);
        chk("wb_addr", l2_cache_addr, exp_wb_addr);
        chk("wb_data", l2_cache_data_out, exp_wb_blk);
        seen_wb = 1;
      end
      if (l2_cache_read) begin
        chk("rf_expected", exp_pending && !exp_hit, 1'b1);
        chk("rf_addr", l2_cache_addr, exp_rf_addr);
        chk("rf_after_wb", seen_wb, exp_wb);
        seen_rf = 1;
      end
      if (cpu_ready && !prev_ready) begin
        chk("ready_expected", exp_pending, 1'b1);
        chk("l1_hit", l1_hit, exp_hit);
        chk("wb_seen", seen_wb, exp_wb);
        chk("rf_seen", seen_rf, !exp_hit);
        if (!exp_wr) exp_hold = exp_rdata;
        chk("cpu_data_out", cpu_data_out, exp_hold);
        exp_pending = 0;
      end else begin
        chk("hit_no_pulse", l1_hit, 1'b0);
        if (cpu_ready) chk("data_hold", cpu_data_out, exp_hold);
      end
      prev_ready = cpu_ready;
    end
  end

  task automatic do_req(input logic [AW-1:0] a, input bit wr, input logic [DW-1:0] wd, input int dly,
                        output logic [DW-1:0] got, output logic got_hit);
    int cyc;
    model_access(a, wr, wd);
    seen_wb = 0;
    seen_rf = 0;
    exp_pending = 1;
    l2_delay = dly;
    cpu_addr = a;
    cpu_data_in = wd;
    cpu_read = 1'b1;
    cpu_write = wr;
    @(posedge clk); #1;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    cpu_addr = ~a;
    chk("busy_after_req", cpu_ready, 1'b0);
    @(posedge clk); #1;
    if (exp_hit) chk("hit_latency", cpu_ready, 1'b1);
    else         chk("miss_busy", cpu_ready, 1'b0);
    cyc = 0;
    while (!cpu_ready && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!cpu_ready) chk("req_timeout", cpu_ready, 1'b1);
    got = cpu_data_out;
    got_hit = l1_hit;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [DW-1:0] d;
    logic          h;
    int            cyc;
    for (int a = 0; a < 2**AW; a++) begin
      m_mem[a]  = 8'(a);
      l2_mem[a] = 8'(a);
    end
    cpu_addr = '0;
    cpu_data_in = '0;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    l2_cache_ready = 1'b0;
    l2_cache_hit = 1'b0;
    l2_cache_data_in = '0;
    #23 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", cpu_ready, 1'b1);
    chk("rst_data", cpu_data_out, 8'h00);
    chk("rst_hit", l1_hit, 1'b0);
    chk("rst_strobes", {l2_cache_read, l2_cache_write}, 2'b00);
    chk("rst_l2_addr", l2_cache_addr, 11'h000);

    do_req(11'h001, 0, 8'h00, 0, d, h);  chk("t1_data", d, 8'h01); chk("t1_hit", h, 1'b0);
    do_req(11'h000, 0, 8'h00, 0, d, h);  chk("t2a_data", d, 8'h00); chk("t2a_hit", h, 1'b1);
    do_req(11'h005, 0, 8'h00, 0, d, h);  chk("t2b_data", d, 8'h05); chk("t2b_hit", h, 1'b1);
    do_req(11'h002, 1, 8'hAB, 0, d, h);  chk("t3w_hit", h, 1'b1);
    do_req(11'h002, 0, 8'h00, 0, d, h);  chk("t3r_data", d, 8'hAB); chk("t3r_hit", h, 1'b1);
    do_req(11'h040, 0, 8'h00, 1, d, h);  chk("t4a_data", d, 8'h40);
    do_req(11'h080, 0, 8'h00, 0, d, h);  chk("t4b_data", d, 8'h80);
    do_req(11'h0C0, 0, 8'h00, 2, d, h);  chk("t4c_data", d, 8'hC0);
    do_req(11'h100, 0, 8'h00, 0, d, h);  chk("t4d_data", d, 8'h00); chk("t4d_hit", h, 1'b0);
    chk("t4_wb_count", n_wb, 1);
    chk("t4_wb_addr", last_wb_addr, 11'h000);
    chk("t4_wb_word2", l2_mem[2], 8'hAB);
`ifdef L1_STATS_EN
    chk("stat_hits", stat_hits, 16'd4);
    chk("stat_misses", stat_misses, 16'd5);
    chk("stat_writebacks", stat_writebacks, 16'd1);
    chk("stat_l2_hits", stat_l2_hits, 16'd4);
`endif

    do_req(11'h123, 1, 8'h5A, 2, d, h);  chk("wmiss_hit", h, 1'b0);
    do_req(11'h123, 0, 8'h00, 0, d, h);  chk("wmiss_rd", d, 8'h5A); chk("wmiss_rd_hit", h, 1'b1);
    do_req(11'h124, 0, 8'h00, 0, d, h);  chk("wmiss_nb", d, 8'h24);
    do_req(11'h002, 0, 8'h00, 3, d, h);  chk("refetch_wb", d, 8'hAB); chk("refetch_hit", h, 1'b0);
    do_req(11'h0C5, 1, 8'h77, 0, d, h);  chk("w0c5_hit", h, 1'b1);
    do_req(11'h140, 0, 8'h00, 0, d, h);
    do_req(11'h180, 0, 8'h00, 0, d, h);
    do_req(11'h1C0, 0, 8'h00, 0, d, h);
    do_req(11'h200, 0, 8'h00, 1, d, h);  chk("t200_data", d, 8'h00);
    chk("wb2_count", n_wb, 2);
    chk("wb2_addr", last_wb_addr, 11'h0C0);
    chk("wb2_word5", l2_mem[11'h0C5], 8'h77);

    // Reset in the middle of a slow refill.
    exp_hit = 0; exp_wr = 0; exp_wb = 0; exp_rf_addr = 11'h010;
    seen_wb = 0; seen_rf = 0; exp_pending = 1; l2_delay = 5;
    cpu_addr = 11'h010;
    cpu_read = 1'b1;
    @(posedge clk); #1;
    cpu_read = 1'b0;
    cyc = 0;
    while (!l2_cache_read && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("t5_strobe_up", l2_cache_read, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rd_drop", l2_cache_read, 1'b0);
    chk("t5_wr_drop", l2_cache_write, 1'b0);
    chk("t5_ready", cpu_ready, 1'b1);
    chk("t5_data", cpu_data_out, 8'h00);
    chk("t5_addr", l2_cache_addr, 11'h000);
    for (int s = 0; s < NS; s++) m_q[s].delete();
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t5_no_wb", n_wb, 2);
`ifdef L1_STATS_EN
    chk("t5_stat_rst", stat_hits, 16'd0);
`endif
    do_req(11'h010, 0, 8'h00, 0, d, h);  chk("t5_reread", d, 8'h10); chk("t5_reread_hit", h, 1'b0);
    do_req(11'h100, 0, 8'h00, 0, d, h);  chk("t5_cold_again", h, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
